// File: rtl/serv_bufreg_w.sv
// Buffer register for the bit-serial core, W bits per cycle: accumulates rs1+imm
// into a 32-bit address/operand register, then shifts and streams it out LSB-first.
module serv_bufreg_w #(
    parameter int W   = 1,
    parameter int MDU = 0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cnt0,
    input  logic          i_cnt1,
    input  logic          i_en,
    input  logic          i_init,
    input  logic          i_mdu_en,
    input  logic          i_rs1_en,
    input  logic          i_imm_en,
    input  logic          i_clr_lsb,
    input  logic          i_sh_signed,
    input  logic          i_mem_half,
    input  logic          i_mem_word,
    input  logic [W-1:0]  i_rs1,
    input  logic [W-1:0]  i_imm,
    output logic [W-1:0]  o_q,
    output logic [1:0]    o_lsb,
    output logic          o_misalign,
    output logic [31:0]   o_dbus_adr,
    output logic [31:0]   o_mdu_rs1
);

    logic [31:0]  data;
    logic [1:0]   lsb;
    logic         c_r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic         c;

    always_comb begin
        a = i_rs1 & {W{i_rs1_en}};
        b = i_imm & {W{i_imm_en}};
        if (i_cnt0 && i_clr_lsb)
            b[0] = 1'b0;
        {c, q} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_r};
    end

    // Carry is only kept across back-to-back enabled chunks, so any idle cycle isolates passes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data <= 32'd0;
            c_r  <= 1'b0;
        end else begin
            c_r <= c & i_en;
            if (i_en) begin
                if (i_init)
                    data <= {q, data[31:W]};
                else
                    data <= {{W{data[31] & i_sh_signed}}, data[31:W]};
            end
        end
    end

    generate
        if (W == 1) begin : gen_lsb_serial
            // Serial mode sees only one address bit per chunk, so the two low bits arrive on cnt0 and cnt1.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    lsb <= 2'b00;
                end else if (i_init && i_en) begin
                    if (i_cnt0)
                        lsb[0] <= q[0];
                    if (i_cnt1)
                        lsb[1] <= q[0];
                end
            end
        end else begin : gen_lsb_wide
            logic unused_cnt1;
            assign unused_cnt1 = i_cnt1;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)
                    lsb <= 2'b00;
                else if (i_init && i_en && i_cnt0)
                    lsb <= q[1:0];
            end
        end
    endgenerate

    assign o_q        = data[W-1:0] & {W{i_en}};
    assign o_dbus_adr = {data[31:2], 2'b00};
    assign o_mdu_rs1  = data;
    assign o_lsb      = ((MDU != 0) && i_mdu_en) ? 2'b00 : lsb;
    assign o_misalign = (i_mem_word & (|lsb)) | (i_mem_half & lsb[0]);

endmodule

// File: tb/tb_serv_bufreg_w.sv
// Self-checking bench for serv_bufreg_w: one instance per legal W (1,2,4,8), checked
// every cycle against a word-level model plus literal expectations for the key cases.
module tb_serv_bufreg_w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] en, init, cnt0, cnt1;
    logic       rs1_en, imm_en, clr_lsb, sh_signed, mem_half, mem_word, mdu_en;
    logic [7:0] rs1_c [4];
    logic [7:0] imm_c [4];

    logic [7:0]  q_o        [4];
    logic [1:0]  lsb_o      [4];
    logic        misalign_o [4];
    logic [31:0] adr_o      [4];
    logic [31:0] mdu_o      [4];

    int errors = 0;
    int checks = 0;

    generate
        for (genvar g = 0; g < 4; g++) begin : gen_dut
            localparam int WG = 1 << g;
            logic [WG-1:0] qw;
            logic [1:0]    lw;
            logic          mis;
            logic [31:0]   aw, mw;
            serv_bufreg_w #(.W(WG), .MDU(g == 0 ? 1 : 0)) dut (
                .i_clk(clk), .i_rst_n(rst_n), .i_cnt0(cnt0[g]), .i_cnt1(cnt1[g]),
                .i_en(en[g]), .i_init(init[g]), .i_mdu_en(mdu_en), .i_rs1_en(rs1_en),
                .i_imm_en(imm_en), .i_clr_lsb(clr_lsb), .i_sh_signed(sh_signed),
                .i_mem_half(mem_half), .i_mem_word(mem_word),
                .i_rs1(rs1_c[g][WG-1:0]), .i_imm(imm_c[g][WG-1:0]),
                .o_q(qw), .o_lsb(lw), .o_misalign(mis), .o_dbus_adr(aw), .o_mdu_rs1(mw)
            );
            assign q_o[g]        = 8'(qw);
            assign lsb_o[g]      = lw;
            assign misalign_o[g] = mis;
            assign adr_o[g]      = aw;
            assign mdu_o[g]      = mw;
        end
    endgenerate

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: operands of the current pass are rebuilt as whole words and added with plain arithmetic.
    logic [31:0] m_data [4];
    logic [1:0]  m_lsb  [4];
    int          m_k    [4];
    logic [63:0] m_a    [4];
    logic [63:0] m_b    [4];
    logic [63:0] ma, mb, msum, mmask;
    logic [7:0]  mq;
    int          mw_;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < 4; g++) begin
                m_data[g] = 32'd0;
                m_lsb[g]  = 2'b00;
            end
        end else begin
            for (int g = 0; g < 4; g++) begin
                if (en[g]) begin
                    mw_   = 1 << g;
                    mmask = (64'd1 << mw_) - 64'd1;
                    if (cnt0[g]) begin
                        m_a[g] = 64'd0;
                        m_b[g] = 64'd0;
                        m_k[g] = 0;
                    end
                    ma = rs1_en ? (64'(rs1_c[g]) & mmask) : 64'd0;
                    mb = imm_en ? (64'(imm_c[g]) & mmask) : 64'd0;
                    if (cnt0[g] && clr_lsb)
                        mb[0] = 1'b0;
                    m_a[g] = m_a[g] | (ma << (m_k[g] * mw_));
                    m_b[g] = m_b[g] | (mb << (m_k[g] * mw_));
                    msum   = m_a[g] + m_b[g];
                    mq     = 8'((msum >> (m_k[g] * mw_)) & mmask);
                    if (init[g]) begin
                        m_data[g] = (m_data[g] >> mw_) | (32'(mq) << (32 - mw_));
                        if (cnt0[g]) begin
                            if (mw_ == 1) m_lsb[g][0] = mq[0];
                            else          m_lsb[g]    = mq[1:0];
                        end
                        if (cnt1[g] && mw_ == 1)
                            m_lsb[g][1] = mq[0];
                    end else begin
                        m_data[g] = sh_signed ? 32'($signed(m_data[g]) >>> mw_) : (m_data[g] >> mw_);
                    end
                    m_k[g]++;
                end
            end
        end
    end

    // Every output of every instance is compared on each falling edge, between updates.
    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            logic [31:0] wm;
            logic [1:0]  el;
            wm = (32'd1 << (1 << g)) - 32'd1;
            el = (g == 0 && mdu_en) ? 2'b00 : m_lsb[g];
            check($sformatf("adr[W%0d]", 1 << g), adr_o[g], {m_data[g][31:2], 2'b00});
            check($sformatf("mdu_rs1[W%0d]", 1 << g), mdu_o[g], m_data[g]);
            check($sformatf("q[W%0d]", 1 << g), 32'(q_o[g]), en[g] ? (m_data[g] & wm) : 32'd0);
            check($sformatf("lsb[W%0d]", 1 << g), 32'(lsb_o[g]), 32'(el));
            check($sformatf("misalign[W%0d]", 1 << g), 32'(misalign_o[g]),
                  32'((mem_word & (|m_lsb[g])) | (mem_half & m_lsb[g][0])));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input int g, input bit ini, input logic [31:0] rs1, input logic [31:0] imm,
                            input bit r_en, input bit i_en_b, input bit clr, input bit sgn,
                            input int nch, input bit gaps);
        int w;
        logic [31:0] mask;
        w    = 1 << g;
        mask = (32'd1 << w) - 32'd1;
        for (int k = 0; k < nch; k++) begin
            if (gaps && !ini && k > 0 && $urandom_range(3) == 0) begin
                en[g] = 1'b0; cnt0[g] = 1'b0; cnt1[g] = 1'b0;
                step();
            end
            en[g]     = 1'b1;
            init[g]   = ini;
            cnt0[g]   = (k == 0);
            cnt1[g]   = (k == 1);
            rs1_c[g]  = 8'((rs1 >> (k * w)) & mask);
            imm_c[g]  = 8'((imm >> (k * w)) & mask);
            rs1_en    = r_en;
            imm_en    = i_en_b;
            clr_lsb   = (k == 0) ? clr : 1'($urandom_range(1));
            sh_signed = sgn;
            mem_half  = 1'($urandom_range(1));
            mem_word  = 1'($urandom_range(1));
            mdu_en    = 1'($urandom_range(1));
            step();
        end
        en[g] = 1'b0; cnt0[g] = 1'b0; cnt1[g] = 1'b0; init[g] = 1'b0;
        step();
    endtask

    task automatic check_sum(input int g, input logic [31:0] exp, input logic [1:0] exp_lsb);
        mdu_en = 1'b0; mem_word = 1'b1; mem_half = 1'b0;
        #1;
        check("sum_data", mdu_o[g], exp);
        check("sum_adr", adr_o[g], {exp[31:2], 2'b00});
        check("sum_lsb", 32'(lsb_o[g]), 32'(exp_lsb));
        check("sum_mis_word", 32'(misalign_o[g]), 32'(|exp_lsb));
        mem_word = 1'b0; mem_half = 1'b1;
        #1;
        check("sum_mis_half", 32'(misalign_o[g]), 32'(exp_lsb[0]));
    endtask

    initial begin
        rst_n = 1'b1;
        en = 4'd0; init = 4'd0; cnt0 = 4'd0; cnt1 = 4'd0;
        rs1_en = 1'b0; imm_en = 1'b0; clr_lsb = 1'b0; sh_signed = 1'b0;
        mem_half = 1'b1; mem_word = 1'b1; mdu_en = 1'b0;
        for (int g = 0; g < 4; g++) begin
            rs1_c[g] = 8'd0; imm_c[g] = 8'd0; m_k[g] = 0; m_a[g] = 64'd0; m_b[g] = 64'd0;
        end
        #1 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            check("reset_adr", adr_o[g], 32'd0);
            check("reset_mis", 32'(misalign_o[g]), 32'd0);
        end
        step(); step();
        rst_n = 1'b1;
        step();

        // Address add with carry chain into the upper bits, then MDU masking of o_lsb.
        run_pass(0, 1'b1, 32'h0000_1000, 32'h0000_07FF, 1'b1, 1'b1, 1'b0, 1'b0, 32, 1'b0);
        check_sum(0, 32'h0000_17FF, 2'd3);
        check("t1_adr", adr_o[0], 32'h0000_17FC);
        mdu_en = 1'b1;
        #1;
        check("mdu_lsb_masked", 32'(lsb_o[0]), 32'd0);
        check("mdu_rs1_low", 32'(mdu_o[0][1:0]), 32'd3);
        mdu_en = 1'b0;
        #1;
        check("mdu_lsb_restored", 32'(lsb_o[0]), 32'd3);

        run_pass(2, 1'b1, 32'h0000_0100, 32'h0000_0003, 1'b1, 1'b1, 1'b1, 1'b0, 8, 1'b0);
        check_sum(2, 32'h0000_0102, 2'd2);

        run_pass(1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 16, 1'b0);
        check_sum(1, 32'h0000_0000, 2'd0);
        run_pass(1, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 16, 1'b0);
        check_sum(1, 32'h0000_0000, 2'd0);

        run_pass(0, 1'b1, 32'h8000_0000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32, 1'b0);
        run_pass(0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 4, 1'b0);
        check("shift_w1_signed", mdu_o[0], 32'hF800_0000);
        run_pass(0, 1'b1, 32'h8000_0000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32, 1'b0);
        run_pass(0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4, 1'b0);
        check("shift_w1_logical", mdu_o[0], 32'h0800_0000);
        run_pass(2, 1'b1, 32'h8000_0000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8, 1'b0);
        run_pass(2, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        check("shift_w4_signed", mdu_o[2], 32'hF800_0000);

        // Reset mid-pass while chunks are still being accumulated.
        for (int k = 0; k < 5; k++) begin
            en[0] = 1'b1; init[0] = 1'b1; cnt0[0] = (k == 0); cnt1[0] = (k == 1);
            rs1_c[0] = 8'd1; imm_c[0] = (k < 2) ? 8'd1 : 8'd0;
            rs1_en = 1'b1; imm_en = 1'b1; clr_lsb = 1'b0; mdu_en = 1'b0;
            step();
        end
        check("pre_reset_nonzero", 32'(mdu_o[0] != 32'd0), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_data", mdu_o[0], 32'd0);
        check("async_reset_lsb", 32'(lsb_o[0]), 32'd0);
        check("async_reset_q", 32'(q_o[0]), 32'd0);
        en[0] = 1'b0; cnt0[0] = 1'b0; cnt1[0] = 1'b0; init[0] = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        run_pass(0, 1'b1, 32'h0000_0010, 32'h0000_0004, 1'b1, 1'b1, 1'b0, 1'b0, 32, 1'b0);
        check_sum(0, 32'h0000_0014, 2'd0);

        // Randomized passes over all widths, with idle gaps inside shift passes.
        for (int it = 0; it < 60; it++) begin
            int g, nch;
            bit ini, r_en, i_en_b, clr, sgn;
            logic [31:0] rs1, imm, exp;
            g      = int'($urandom_range(3));
            ini    = 1'($urandom_range(1));
            nch    = ini ? (32 >> g) : int'($urandom_range(32 >> g, 1));
            r_en   = ($urandom_range(7) != 0);
            i_en_b = ($urandom_range(7) != 0);
            clr    = 1'($urandom_range(1));
            sgn    = 1'($urandom_range(1));
            rs1    = $urandom;
            imm    = $urandom;
            run_pass(g, ini, rs1, imm, r_en, i_en_b, clr, sgn, nch, 1'b1);
            if (ini) begin
                exp = (r_en ? rs1 : 32'd0) + ((i_en_b ? imm : 32'd0) & (clr ? 32'hFFFF_FFFE : 32'hFFFF_FFFF));
                check_sum(g, exp, exp[1:0]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
